mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Memory-side arbiter that answers the icache and dcache `caches_if` request ports and drives the single-ported RAM. It grants one cache at a time and holds the dcache grant across its two-word block transfers, both fills and writebacks. It alternates priority between the caches so neither starves. It returns `iwait`/`dwait`, `iload`/`dload` to the caches and forwards the winner's request to RAM.

## Interface
- ACCESS_ST, 2'b10: `ramstate` encoding that marks a completed RAM word.
- ERROR_ST, 2'b11: `ramstate` encoding that marks a RAM fault.
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  high until the icache word completes.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins if asserted together with dREN.
- daddr  in  32  dcache word address; bit 2 is the block offset (0 = word0, 1 = word1).
- dstore  in  32  dcache write data.
- dwait  out  1  high until the dcache word completes.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- ram_err  out  1  sticky flag; set when ERROR_ST is seen while granted.

## Operation
- States: IDLE, DGNT, IGNT.
- `last_d` is a 1-bit register. It is set when a dcache grant ends and cleared when an icache grant ends.
- IDLE:
  - No RAM enables are driven; `ramaddr` = 0, `ramstore` = 0.
  - `iwait` = `dwait` = 1; `iload` = `dload` = 0.
  - Both caches requesting: go to IGNT if `last_d` = 1, else DGNT.
  - Only one cache requesting: go to that cache's grant state.
  - No request: stay in IDLE.
- DGNT:
  - `ramWEN` = dWEN; `ramREN` = dREN & ~dWEN; `ramaddr` = daddr; `ramstore` = dstore.
  - `dload` = ramload; `dwait` = (ramstate != ACCESS_ST).
  - `iwait` = 1; `iload` = 0.
  - On ACCESS with daddr[2] = 1: go to IDLE; set `last_d`.
  - On ACCESS with daddr[2] = 0: stay in DGNT, holding the lock for word1.
  - dREN and dWEN both low in DGNT: abandon the burst; go to IDLE; set `last_d`.
- IGNT:
  - `ramREN` = 1; `ramaddr` = iaddr; `iload` = ramload; `iwait` = (ramstate != ACCESS_ST).
  - `dwait` = 1; `dload` = 0.
  - On ACCESS: go to IDLE; clear `last_d`.
  - iREN dropped: go to IDLE; clear `last_d`.
- Any grant state, ramstate = ERROR_ST: waits stay 1, state is unchanged, `ram_err` is set (sticky until reset).
- Data paths are combinational passthrough. No width conversion; addresses go to RAM unmodified.

## Timing
- Reset values (asynchronous, on nRST low):
  - state = IDLE, `last_d` = 0, `ram_err` = 0.
  - `ramREN` = `ramWEN` = 0; `iwait` = `dwait` = 1; `iload` = `dload` = `ramaddr` = `ramstore` = 0.
- Reset mid-transfer: RAM enables drop asynchronously; no partial burst resumes.
- Arbitration costs one cycle: a request first seen in IDLE is forwarded to RAM in the following cycle.
- Wait handshake: wait is low only in the cycle where ramstate = ACCESS. The cache samples load data and advances its address on that edge.
- Back-to-back dcache words: word1 is forwarded in the cycle after word0's ACCESS, with no IDLE bubble.
- Between grants there is always exactly one IDLE cycle, including consecutive requests from the same cache.
- ramstate is sampled only in grant states; it is ignored in IDLE.

## Test plan
- Icache only: reset, iREN = 1, iaddr = 0x40, RAM returns ACCESS after 2 BUSY cycles with ramload = 0xDEADBEEF. Required: `ramREN` rises 1 cycle after the request; `iwait` low for exactly 1 cycle with `iload` = 0xDEADBEEF; state returns to IDLE.
- Dcache writeback burst: dWEN with daddr = 0x100 then 0x104, dstore = 0x11 then 0x22, iREN held high throughout. Required: RAM sees both writes consecutively (0x100/0x11, then 0x104/0x22); `iwait` stays 1 until the burst ends; then IGNT.
- Simultaneous requests after reset: iREN and dREN asserted in the same cycle. Required: dcache granted first (`last_d` = 0); icache granted next.
- Dual-asserted dREN = dWEN = 1: required `ramWEN` = 1 and `ramREN` = 0.
- ramstate = ERROR_ST during IGNT: required `iwait` stays 1 and `ram_err` = 1. Then assert nRST: required `ram_err` = 0 and `ramREN` = 0 immediately, asynchronously.
- Dcache abandons after word0: dREN drops after word0's ACCESS. Required: state goes to IDLE and `last_d` = 1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache request ports, the arbiter and the single-ported RAM.
// The arbiter connects through the slave modport; the cache/RAM side drives through master.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic        ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Grants the single-ported RAM to one cache at a time, alternating priority between
// icache and dcache and holding the dcache grant across its two-word block transfers.
module mem_arbiter (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] ACCESS_ST = 2'b10;
  localparam logic [1:0] ERROR_ST  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DGNT = 2'b01,
    IGNT = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   ram_err_q, ram_err_d;

  logic d_req;
  logic ram_access;
  logic ram_error;

  assign d_req      = bus.dREN | bus.dWEN;
  assign ram_access = (bus.ramstate == ACCESS_ST);
  assign ram_error  = (bus.ramstate == ERROR_ST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      ram_err_q <= ram_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    ram_err_d    = ram_err_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0;
    bus.ramstore = 32'h0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = 32'h0;
    bus.dload    = 32'h0;

    unique case (state_q)
      IDLE: begin
        // Contention goes to whichever cache did not own the last grant.
        if (bus.iREN && d_req) begin
          state_d = last_d_q ? IGNT : DGNT;
        end else if (bus.iREN) begin
          state_d = IGNT;
        end else if (d_req) begin
          state_d = DGNT;
        end
      end

      DGNT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = bus.ramload;
        bus.dwait    = ~ram_access;
        // A RAM fault freezes the grant; word0 completion keeps the lock for word1.
        if (ram_error) begin
          ram_err_d = 1'b1;
        end else if (!d_req || (ram_access && bus.daddr[2])) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end
      end

      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        bus.iload   = bus.ramload;
        bus.iwait   = ~ram_access;
        if (ram_error) begin
          ram_err_d = 1'b1;
        end else if (!bus.iREN || ram_access) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_err = ram_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; every output is compared each cycle
// against an ownership-based model of who holds the RAM.
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  typedef enum int {NOBODY, ICACHE, DCACHE} owner_t;

  logic CLK;
  logic nRST;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  owner_t owner;
  bit     lastD;
  bit     errSeen;

  logic        curIren, curDren, curDwen;
  logic [31:0] curIaddr, curDaddr, curDstore, curRamload;
  logic [1:0]  curRamstate;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    owner   = NOBODY;
    lastD   = 1'b0;
    errSeen = 1'b0;
  endtask

  // Whoever owns the RAM sees their request forwarded; the other cache just waits.
  task automatic checkOutput();
    bit iOwn, dOwn, done;
    iOwn = (owner == ICACHE);
    dOwn = (owner == DCACHE);
    done = (curRamstate == ACCESS);
    check("iwait",    bus.iwait,    {31'b0, !(iOwn && done)});
    check("dwait",    bus.dwait,    {31'b0, !(dOwn && done)});
    check("iload",    bus.iload,    iOwn ? curRamload : 32'h0);
    check("dload",    bus.dload,    dOwn ? curRamload : 32'h0);
    check("ramREN",   bus.ramREN,   {31'b0, iOwn || (dOwn && curDren && !curDwen)});
    check("ramWEN",   bus.ramWEN,   {31'b0, dOwn && curDwen});
    check("ramaddr",  bus.ramaddr,  iOwn ? curIaddr : (dOwn ? curDaddr : 32'h0));
    check("ramstore", bus.ramstore, dOwn ? curDstore : 32'h0);
    check("ram_err",  bus.ram_err,  {31'b0, errSeen});
  endtask

  task automatic applyStimulus(input logic iren, input logic [31:0] ia,
                               input logic dren, input logic dwen,
                               input logic [31:0] da, input logic [31:0] ds,
                               input logic [31:0] rl, input logic [1:0] rs);
    owner_t nextOwner;
    bit     nextLastD, nextErr, dWants;
    curIren = iren; curIaddr = ia; curDren = dren; curDwen = dwen;
    curDaddr = da; curDstore = ds; curRamload = rl; curRamstate = rs;
    bus.iREN = iren; bus.iaddr = ia; bus.dREN = dren; bus.dWEN = dwen;
    bus.daddr = da; bus.dstore = ds; bus.ramload = rl; bus.ramstate = rs;
    #1;
    checkOutput();
    nextOwner = owner;
    nextLastD = lastD;
    nextErr   = errSeen;
    dWants    = dren || dwen;
    if (owner == NOBODY) begin
      if (iren && dWants)  nextOwner = lastD ? ICACHE : DCACHE;
      else if (iren)       nextOwner = ICACHE;
      else if (dWants)     nextOwner = DCACHE;
    end else if (rs == ERROR) begin
      nextErr = 1'b1;
    end else if (owner == DCACHE) begin
      if (!dWants || (rs == ACCESS && da[2])) begin
        nextOwner = NOBODY;
        nextLastD = 1'b1;
      end
    end else begin
      if (!iren || rs == ACCESS) begin
        nextOwner = NOBODY;
        nextLastD = 1'b0;
      end
    end
    @(posedge CLK);
    if (nRST) begin
      owner   = nextOwner;
      lastD   = nextLastD;
      errSeen = nextErr;
    end
    @(negedge CLK);
  endtask

  task automatic pulseReset();
    nRST = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] da;
    nRST = 1'b0;
    curIren = 0; curIaddr = 0; curDren = 0; curDwen = 0;
    curDaddr = 0; curDstore = 0; curRamload = 0; curRamstate = FREE;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 32'hFFFF_FFFF; bus.ramstate = ACCESS;
    curRamload = 32'hFFFF_FFFF; curRamstate = ACCESS;
    #2;
    modelReset();
    checkOutput();
    @(negedge CLK);
    nRST = 1'b1;

    $display("[TB] icache-only read");
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'h0, FREE);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'h0, BUSY);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'h0, BUSY);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, ACCESS);
    applyStimulus(0, 32'h40, 0, 0, 0, 0, 32'h0, FREE);

    $display("[TB] dcache writeback burst with icache pending");
    applyStimulus(1, 32'h80, 0, 1, 32'h100, 32'h11, 0, FREE);
    applyStimulus(1, 32'h80, 0, 1, 32'h100, 32'h11, 0, BUSY);
    applyStimulus(1, 32'h80, 0, 1, 32'h100, 32'h11, 0, ACCESS);
    applyStimulus(1, 32'h80, 0, 1, 32'h104, 32'h22, 0, ACCESS);
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, FREE);
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 32'h5, ACCESS);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, FREE);

    $display("[TB] simultaneous requests after reset");
    pulseReset();
    applyStimulus(1, 32'hA0, 1, 0, 32'h200, 0, 0, FREE);
    applyStimulus(1, 32'hA0, 1, 0, 32'h200, 0, 32'h1234, ACCESS);
    applyStimulus(1, 32'hA0, 1, 0, 32'h204, 0, 32'h5678, ACCESS);
    applyStimulus(1, 32'hA0, 0, 0, 0, 0, 0, FREE);
    applyStimulus(1, 32'hA0, 0, 0, 0, 0, 32'h9, ACCESS);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, FREE);

    $display("[TB] dREN and dWEN together");
    applyStimulus(0, 0, 1, 1, 32'h300, 32'hAA, 0, FREE);
    applyStimulus(0, 0, 1, 1, 32'h300, 32'hAA, 0, BUSY);
    check("dual_ramWEN", bus.ramWEN, 32'h1);
    check("dual_ramREN", bus.ramREN, 32'h0);
    applyStimulus(0, 0, 1, 1, 32'h300, 32'hAA, 0, ACCESS);
    applyStimulus(0, 0, 1, 1, 32'h304, 32'hBB, 0, ACCESS);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, FREE);

    $display("[TB] RAM error during icache grant, then async reset");
    applyStimulus(1, 32'hC0, 0, 0, 0, 0, 0, FREE);
    applyStimulus(1, 32'hC0, 0, 0, 0, 0, 32'h77, ERROR);
    applyStimulus(1, 32'hC0, 0, 0, 0, 0, 32'h77, ERROR);
    #2;
    nRST = 1'b0;
    #1;
    check("async_ram_err", bus.ram_err, 32'h0);
    check("async_ramREN",  bus.ramREN,  32'h0);
    modelReset();
    @(negedge CLK);
    nRST = 1'b1;

    $display("[TB] dcache abandons after word0");
    applyStimulus(0, 0, 1, 0, 32'h400, 0, 0, FREE);
    applyStimulus(0, 0, 1, 0, 32'h400, 0, 32'h77, ACCESS);
    applyStimulus(0, 0, 0, 0, 32'h404, 0, 0, BUSY);
    applyStimulus(1, 32'hE0, 1, 0, 32'h500, 0, 0, FREE);
    applyStimulus(1, 32'hE0, 1, 0, 32'h500, 0, 0, BUSY);
    check("abandon_icache_next", bus.ramaddr, 32'hE0);
    applyStimulus(1, 32'hE0, 1, 0, 32'h500, 0, 32'h3, ACCESS);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 15))
        0:                rs = ERROR;
        1, 2, 3, 4, 5, 6: rs = ACCESS;
        7, 8, 9, 10, 11:  rs = BUSY;
        default:          rs = FREE;
      endcase
      da = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                    da, $urandom, $urandom, rs);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
